ifc_initiator: RTL

IFC_INITIATOR -- requirements
Module: ifc_initiator

---
 rtl/ifc_initiator.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ifc_initiator.sv
// Command-queue initiator: buffers read/write commands and issues them in order to a target.
// Optional stall timeout enabled by defining IFC_INIT_TIMEOUT_EN.
module ifc_initiator #(
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [2:0] cmd_addr,
    input  logic       cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [2:0] rsp_addr,
    output logic       rsp_data,
    output logic [2:0] write_address,
    output logic       write_data,
    output logic       write_en,
    input  logic       write_rdy,
    output logic [2:0] read_address,
    output logic       read_en,
    input  logic       read_rdy,
    input  logic       read_data,
    output logic       busy,
    output logic       timeout_err
);
    // state | meaning
    // IDLE  | queue empty, target outputs parked at 0
    // ISSUE | head entry present and presented to the target
    localparam int AW = $clog2(CMD_DEPTH);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          r_state, w_state_nxt;
    logic [4:0]      r_q_mem [CMD_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_ready_en;
    logic            r_rsp_valid;
    logic [2:0]      r_rsp_addr;
    logic            r_rsp_data;

    logic [4:0]      w_head;
    logic            w_push, w_pop, w_fire, w_drop;
    logic            w_write_en, w_read_en;

    assign w_head    = r_q_mem[r_rd_ptr];
    assign cmd_ready = r_ready_en && (r_count != (AW+1)'(CMD_DEPTH));
    assign w_push    = cmd_valid && cmd_ready;
    assign w_fire    = w_write_en || w_read_en;
    assign w_pop     = w_fire || w_drop;
    assign busy      = (r_count != '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_write_en    = 1'b0;
        w_read_en     = 1'b0;
        write_address = 3'd0;
        write_data    = 1'b0;
        read_address  = 3'd0;
        case (r_state)
            IDLE: begin
                if (r_count != '0 || w_push) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                write_address = w_head[3:1];
                write_data    = w_head[0];
                read_address  = w_head[3:1];
                w_write_en    = w_head[4] && write_rdy;
                // A read needs somewhere to put its data before it may fire.
                w_read_en     = !w_head[4] && read_rdy && (!r_rsp_valid || rsp_ready);
                if (w_pop && !w_push && r_count == (AW+1)'(1)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign write_en = w_write_en;
    assign read_en  = w_read_en;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ready_en <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_q_mem[r_wr_ptr] <= {cmd_write, cmd_addr, cmd_data};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= 3'd0;
            r_rsp_data  <= 1'b0;
        end else if (w_read_en) begin
            r_rsp_valid <= 1'b1;
            r_rsp_addr  <= w_head[3:1];
            r_rsp_data  <= read_data;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_data  = r_rsp_data;

`ifdef IFC_INIT_TIMEOUT_EN
    logic [7:0] r_stall;
    logic       r_timeout_err;

    assign w_drop = (r_state == ISSUE) && !w_fire && (r_stall == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stall       <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state != ISSUE || w_fire || w_drop) r_stall <= 8'd0;
            else                                      r_stall <= r_stall + 8'd1;
            if (w_drop) r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_drop      = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
